ub_dma_loader: RTL and testbench

UB_DMA_LOADER -- requirements
Module: ub_dma_loader

---
 rtl/ub_dma_loader.sv | 231 +++++++++++++++++++++++
 tb/tb_ub_dma_loader.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ub_dma_loader.sv
// ub_dma_loader (rev 1.0): word-serial DMA between external memory and the unified buffer.
// Store path (UB -> external) is built only when UB_DMA_STORE_EN is defined.
`default_nettype none

module ub_dma_loader #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 10,
  parameter int EXT_AW = 32,
  parameter int LEN_W  = ADDR_W + 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_dir,
  input  logic [EXT_AW-1:0] cmd_ext_addr,
  input  logic [ADDR_W-1:0] cmd_ub_addr,
  input  logic [LEN_W-1:0]  cmd_len,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic              ext_req_valid,
  input  logic              ext_req_ready,
  output logic              ext_req_we,
  output logic [EXT_AW-1:0] ext_addr,
  output logic [DATA_W-1:0] ext_wdata,
  input  logic              ext_rsp_valid,
  input  logic [DATA_W-1:0] ext_rdata,
  output logic              dma_write_en,
  output logic              dma_read_en,
  output logic [ADDR_W-1:0] dma_addr,
  output logic [DATA_W-1:0] dma_data_in,
  input  logic [DATA_W-1:0] dma_data_out
);

  typedef enum logic [3:0] {
    IDLE   = 4'd0,
    CHECK  = 4'd1,
    L_REQ  = 4'd2,
    L_WAIT = 4'd3,
    L_WR   = 4'd4,
    S_RD   = 4'd5,
    S_CAP  = 4'd6,
    S_REQ  = 4'd7,
    DONE   = 4'd8
  } state_t;

`ifdef UB_DMA_STORE_EN
  localparam logic STORE_EN = 1'b1;
`else
  localparam logic STORE_EN = 1'b0;
`endif

  localparam logic [ADDR_W+1:0] UB_WORDS  = (ADDR_W+2)'(1) << ADDR_W;
  localparam logic [EXT_AW-1:0] EXT_STEP  = EXT_AW'(DATA_W / 8);
  localparam logic [LEN_W-1:0]  LAST_WORD = LEN_W'(1);

  state_t            state_q, state_d;
  logic              dir_q, dir_d;
  logic [EXT_AW-1:0] ext_addr_q, ext_addr_d;
  logic [ADDR_W-1:0] ub_addr_q, ub_addr_d;
  logic [LEN_W-1:0]  rem_q, rem_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              err_d;

  logic              cmd_ready_q;
  logic              busy_q;
  logic              done_q;
  logic              err_q;
  logic              ext_req_valid_q;
  logic              dma_write_en_q;

  logic [ADDR_W+1:0] end_addr;
  logic              range_bad;
  logic              last_word;

  // Two spare bits so a transfer ending exactly at the top of the UB cannot wrap.
  assign end_addr  = {2'b00, ub_addr_q} + (ADDR_W+2)'(rem_q);
  assign range_bad = (end_addr > UB_WORDS);
  assign last_word = (rem_q == LAST_WORD);

  always_comb begin
    state_d    = state_q;
    dir_d      = dir_q;
    ext_addr_d = ext_addr_q;
    ub_addr_d  = ub_addr_q;
    rem_d      = rem_q;
    data_d     = data_q;
    err_d      = 1'b0;

    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          dir_d      = cmd_dir;
          ext_addr_d = cmd_ext_addr;
          ub_addr_d  = cmd_ub_addr;
          rem_d      = cmd_len;
          state_d    = CHECK;
        end
      end

      CHECK: begin
        if (range_bad || (dir_q && !STORE_EN)) begin
          err_d   = 1'b1;
          state_d = DONE;
        end else if (rem_q == '0) begin
          state_d = DONE;
        end else begin
          state_d = (dir_q && STORE_EN) ? S_RD : L_REQ;
        end
      end

      L_REQ: begin
        if (ext_req_ready) begin
          state_d = L_WAIT;
        end
      end

      // Responses arriving in any other state are deliberately dropped.
      L_WAIT: begin
        if (ext_rsp_valid) begin
          data_d  = ext_rdata;
          state_d = L_WR;
        end
      end

      L_WR: begin
        ub_addr_d  = ub_addr_q + ADDR_W'(1);
        ext_addr_d = ext_addr_q + EXT_STEP;
        rem_d      = rem_q - LAST_WORD;
        state_d    = last_word ? DONE : L_REQ;
      end

`ifdef UB_DMA_STORE_EN
      S_RD: begin
        state_d = S_CAP;
      end

      S_CAP: begin
        data_d  = dma_data_out;
        state_d = S_REQ;
      end

      S_REQ: begin
        if (ext_req_ready) begin
          ub_addr_d  = ub_addr_q + ADDR_W'(1);
          ext_addr_d = ext_addr_q + EXT_STEP;
          rem_d      = rem_q - LAST_WORD;
          state_d    = last_word ? DONE : S_RD;
        end
      end
`endif

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Strobes are registered from the next state so they line up with the state they describe.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q         <= IDLE;
      dir_q           <= 1'b0;
      ext_addr_q      <= '0;
      ub_addr_q       <= '0;
      rem_q           <= '0;
      data_q          <= '0;
      cmd_ready_q     <= 1'b1;
      busy_q          <= 1'b0;
      done_q          <= 1'b0;
      err_q           <= 1'b0;
      ext_req_valid_q <= 1'b0;
      dma_write_en_q  <= 1'b0;
    end else begin
      state_q         <= state_d;
      dir_q           <= dir_d;
      ext_addr_q      <= ext_addr_d;
      ub_addr_q       <= ub_addr_d;
      rem_q           <= rem_d;
      data_q          <= data_d;
      cmd_ready_q     <= (state_d == IDLE);
      busy_q          <= (state_d != IDLE);
      done_q          <= (state_d == DONE);
      err_q           <= err_d;
      ext_req_valid_q <= (state_d == L_REQ) || (state_d == S_REQ);
      dma_write_en_q  <= (state_d == L_WR);
    end
  end

`ifdef UB_DMA_STORE_EN
  logic dma_read_en_q;
  logic ext_req_we_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      dma_read_en_q <= 1'b0;
      ext_req_we_q  <= 1'b0;
    end else begin
      dma_read_en_q <= (state_d == S_RD);
      ext_req_we_q  <= (state_d == S_REQ);
    end
  end

  assign dma_read_en = dma_read_en_q;
  assign ext_req_we  = ext_req_we_q;
`else
  logic unused_dma_data_out;
  assign unused_dma_data_out = ^dma_data_out;
  assign dma_read_en         = 1'b0;
  assign ext_req_we          = 1'b0;
`endif

  assign cmd_ready     = cmd_ready_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign err           = err_q;
  assign ext_req_valid = ext_req_valid_q;
  assign ext_addr      = ext_addr_q;
  assign ext_wdata     = data_q;
  assign dma_write_en  = dma_write_en_q;
  assign dma_addr      = ub_addr_q;
  assign dma_data_in   = data_q;

endmodule

`default_nettype wire

// File: tb/tb_ub_dma_loader.sv
// tb_ub_dma_loader: directed + randomized commands against a queue-based transfer model.
// Models external memory and the UB; honours UB_DMA_STORE_EN like the design.
`default_nettype none

module tb_ub_dma_loader;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 10;
  localparam int EXT_AW = 32;
  localparam int LEN_W  = ADDR_W + 1;

`ifdef UB_DMA_STORE_EN
  localparam bit STORE_EN = 1'b1;
`else
  localparam bit STORE_EN = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              reset;
  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_dir;
  logic [EXT_AW-1:0] cmd_ext_addr;
  logic [ADDR_W-1:0] cmd_ub_addr;
  logic [LEN_W-1:0]  cmd_len;
  logic              busy, done, err;
  logic              ext_req_valid;
  logic              ext_req_ready;
  logic              ext_req_we;
  logic [EXT_AW-1:0] ext_addr;
  logic [DATA_W-1:0] ext_wdata;
  logic              ext_rsp_valid;
  logic [DATA_W-1:0] ext_rdata;
  logic              dma_write_en, dma_read_en;
  logic [ADDR_W-1:0] dma_addr;
  logic [DATA_W-1:0] dma_data_in;
  logic [DATA_W-1:0] dma_data_out;

  always #5 clk = ~clk;

  ub_dma_loader #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .EXT_AW(EXT_AW), .LEN_W(LEN_W)
  ) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_dir(cmd_dir),
    .cmd_ext_addr(cmd_ext_addr), .cmd_ub_addr(cmd_ub_addr), .cmd_len(cmd_len),
    .busy(busy), .done(done), .err(err),
    .ext_req_valid(ext_req_valid), .ext_req_ready(ext_req_ready), .ext_req_we(ext_req_we),
    .ext_addr(ext_addr), .ext_wdata(ext_wdata),
    .ext_rsp_valid(ext_rsp_valid), .ext_rdata(ext_rdata),
    .dma_write_en(dma_write_en), .dma_read_en(dma_read_en), .dma_addr(dma_addr),
    .dma_data_in(dma_data_in), .dma_data_out(dma_data_out)
  );

  typedef struct { logic [31:0] addr; logic we; logic [31:0] data; } ext_t;
  typedef struct { logic [9:0] addr; logic [31:0] data; } wr_t;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] ub_mem [1024];
  ext_t        exp_ext [$];
  wr_t         exp_wr  [$];
  int          stall_cnt, n_done, n_wr;
  logic        last_err;
  bit          fast_rsp;
  bit          rsp_pend;
  int          rsp_dly;
  logic [31:0] rsp_addr;
  bit          rd_pend;
  logic [9:0]  rd_addr;
  bit          prev_stall;
  logic [31:0] prev_addr, prev_wdata;
  logic        prev_we;

  function automatic logic [31:0] ext_word(input logic [31:0] a);
    return 32'hDEAD0000 + ((a - 32'h1000) >> 2);
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One cycle: observe DUT outputs at the falling edge, then drive the external/UB side.
  task automatic step();
    @(negedge clk);
    if (dma_write_en || dma_read_en) chk("wr_rd_exclusive", dma_write_en && dma_read_en, 0);
    if (prev_stall) begin
      chk("stall_valid", ext_req_valid, 1);
      chk("stall_addr", ext_addr, prev_addr);
      chk("stall_we", ext_req_we, prev_we);
      if (prev_we) chk("stall_wdata", ext_wdata, prev_wdata);
    end
    if (dma_write_en) begin
      n_wr++;
      if (exp_wr.size() == 0) chk("dma_write_unexpected", dma_write_en, 0);
      else begin
        wr_t w;
        w = exp_wr.pop_front();
        chk("dma_write_addr", dma_addr, w.addr);
        chk("dma_write_data", dma_data_in, w.data);
      end
      ub_mem[dma_addr] = dma_data_in;
    end
    if (ext_req_valid && exp_ext.size() == 0) chk("ext_req_unexpected", ext_req_valid, 0);
    if (err) chk("err_with_done", done, 1);
    if (done) begin
      n_done++;
      last_err = err;
      chk("busy_at_done", busy, 1);
    end

    dma_data_out = rd_pend ? ub_mem[rd_addr] : $urandom();
    rd_pend = dma_read_en;
    rd_addr = dma_addr;

    if (rsp_pend && rsp_dly == 0) begin
      ext_rsp_valid = 1'b1;
      ext_rdata     = ext_word(rsp_addr);
      rsp_pend      = 1'b0;
    end else begin
      if (rsp_pend) rsp_dly--;
      ext_rsp_valid = !rsp_pend && ($urandom_range(0, 5) == 0);
      ext_rdata     = $urandom();
    end

    if (stall_cnt > 0 && ext_req_valid) begin
      ext_req_ready = 1'b0;
      stall_cnt--;
    end else begin
      ext_req_ready = fast_rsp ? 1'b1 : ($urandom_range(0, 3) != 0);
    end
    prev_stall = ext_req_valid && !ext_req_ready;
    prev_addr  = ext_addr;
    prev_we    = ext_req_we;
    prev_wdata = ext_wdata;

    if (ext_req_valid && ext_req_ready && exp_ext.size() != 0) begin
      ext_t e;
      e = exp_ext.pop_front();
      chk("ext_req_addr", ext_addr, e.addr);
      chk("ext_req_we", ext_req_we, e.we);
      if (e.we) chk("ext_req_wdata", ext_wdata, e.data);
      else begin
        rsp_pend = 1'b1;
        rsp_dly  = fast_rsp ? 0 : $urandom_range(0, 2);
        rsp_addr = ext_addr;
      end
    end
  endtask

  // Reference model: the list of external requests and UB writes a command must produce.
  task automatic build_exp(input logic dir, input logic [31:0] ext, input logic [9:0] ub,
                           input int len, output bit bad);
    bad = (int'(ub) + len > 1024) || (dir && !STORE_EN);
    exp_ext.delete();
    exp_wr.delete();
    if (!bad) begin
      for (int i = 0; i < len; i++) begin
        ext_t e;
        wr_t  w;
        e.addr = ext + 32'(4 * i);
        e.we   = dir;
        e.data = dir ? ub_mem[ub + 10'(i)] : 32'h0;
        exp_ext.push_back(e);
        if (!dir) begin
          w.addr = ub + 10'(i);
          w.data = ext_word(e.addr);
          exp_wr.push_back(w);
        end
      end
    end
  endtask

  task automatic run_cmd(input logic dir, input logic [31:0] ext, input logic [9:0] ub,
                         input int len, input int stall, input bit pulse, input string tag);
    bit bad;
    int k;
    int done_k;
    step();
    build_exp(dir, ext, ub, len, bad);
    n_done    = 0;
    last_err  = 1'bx;
    stall_cnt = stall;
    cmd_dir = dir; cmd_ext_addr = ext; cmd_ub_addr = ub; cmd_len = LEN_W'(len);
    cmd_valid = 1'b1;
    k = 0;
    while (!cmd_ready && k < 20) begin step(); k++; end
    chk({tag, "_accept"}, cmd_ready, 1);
    if (!cmd_ready) begin cmd_valid = 1'b0; return; end
    k = 0;
    done_k = -1;
    while (done_k < 0 && k < 60 + 12 * len) begin
      step();
      k++;
      if (k == 1) begin
        cmd_valid    = 1'b0;
        cmd_dir      = 1'($urandom());
        cmd_ext_addr = $urandom();
        cmd_ub_addr  = 10'($urandom());
        cmd_len      = LEN_W'($urandom());
      end
      if (pulse && k == 3) begin
        chk({tag, "_ready_while_busy"}, cmd_ready, 0);
        cmd_valid = 1'b1;
      end
      if (k == 4) cmd_valid = 1'b0;
      if (n_done > 0) done_k = k;
    end
    cmd_valid = 1'b0;
    chk({tag, "_done_seen"}, done_k > 0, 1);
    chk({tag, "_err"}, last_err, bad);
    if (bad || len == 0) chk({tag, "_done_latency"}, done_k, 2);
    chk({tag, "_ext_left"}, exp_ext.size(), 0);
    chk({tag, "_wr_left"}, exp_wr.size(), 0);
    step();
    chk({tag, "_idle_ready"}, cmd_ready, 1);
    chk({tag, "_idle_busy"}, busy, 0);
    chk({tag, "_one_done"}, n_done, 1);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_cmd_ready"}, cmd_ready, 1);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_err"}, err, 0);
    chk({tag, "_ext_req_valid"}, ext_req_valid, 0);
    chk({tag, "_ext_req_we"}, ext_req_we, 0);
    chk({tag, "_ext_addr"}, ext_addr, 0);
    chk({tag, "_ext_wdata"}, ext_wdata, 0);
    chk({tag, "_dma_write_en"}, dma_write_en, 0);
    chk({tag, "_dma_read_en"}, dma_read_en, 0);
    chk({tag, "_dma_addr"}, dma_addr, 0);
    chk({tag, "_dma_data_in"}, dma_data_in, 0);
  endtask

  initial begin
    bit bad;
    int k;
    int wr0;
    reset = 1'b1;
    cmd_valid = 1'b0; cmd_dir = 1'b0; cmd_ext_addr = '0; cmd_ub_addr = '0; cmd_len = '0;
    ext_req_ready = 1'b0; ext_rsp_valid = 1'b0; ext_rdata = '0; dma_data_out = '0;
    fast_rsp = 1'b0; rsp_pend = 1'b0; rsp_dly = 0; rsp_addr = '0;
    rd_pend = 1'b0; rd_addr = '0; prev_stall = 1'b0; prev_addr = '0; prev_wdata = '0;
    prev_we = 1'b0; stall_cnt = 0; n_done = 0; n_wr = 0; last_err = 1'b0;
    for (int i = 0; i < 1024; i++) ub_mem[i] = $urandom();

    // Reset takes effect before any clock edge.
    #1 reset = 1'b0;
    #1 check_reset_outputs("por_async");
    repeat (2) @(negedge clk);
    check_reset_outputs("por_clocked");
    reset = 1'b1;

    fast_rsp = 1'b1;
    run_cmd(1'b0, 32'h1000, 10'h010, 4, 0, 1'b0, "load4");
    run_cmd(1'b0, 32'h1000, 10'h020, 0, 0, 1'b0, "len0");
    run_cmd(1'b0, 32'h1000, 10'h3FE, 4, 0, 1'b0, "overflow");
    run_cmd(1'b0, 32'h4000, 10'h3FC, 4, 0, 1'b0, "top_fit");
    run_cmd(1'b0, 32'h4000, 10'h3FD, 4, 0, 1'b0, "top_over");
    fast_rsp = 1'b0;
    run_cmd(1'b0, 32'h5000, 10'h080, 3, 5, 1'b1, "stall");

    for (int j = 0; j < 4; j++) ub_mem[10'h100 + j] = 32'hBEEF0000 + 32'(j);
    run_cmd(1'b1, 32'h2000, 10'h100, 4, 0, 1'b0, "store4");

    // Reset in the middle of a len-8 load.
    step();
    build_exp(1'b0, 32'h3000, 10'h040, 8, bad);
    cmd_dir = 1'b0; cmd_ext_addr = 32'h3000; cmd_ub_addr = 10'h040; cmd_len = LEN_W'(8);
    cmd_valid = 1'b1;
    chk("midrst_accept", cmd_ready, 1);
    wr0 = n_wr;
    n_done = 0;
    step();
    cmd_valid = 1'b0;
    k = 0;
    while (n_wr - wr0 < 2 && k < 200) begin step(); k++; end
    chk("midrst_two_writes", n_wr - wr0, 2);
    step();
    reset = 1'b0;
    #1 check_reset_outputs("midrst");
    exp_ext.delete(); exp_wr.delete();
    rsp_pend = 1'b0; rd_pend = 1'b0; prev_stall = 1'b0; stall_cnt = 0;
    ext_req_ready = 1'b0; ext_rsp_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("midrst_no_done", n_done, 0);
    check_reset_outputs("midrst_held");
    reset = 1'b1;
    run_cmd(1'b0, 32'h3100, 10'h050, 2, 0, 1'b0, "post_rst");

    for (int n = 0; n < 20; n++) begin
      logic       d;
      logic [9:0] u;
      int         l;
      d = 1'($urandom_range(0, 1));
      l = $urandom_range(0, 12);
      u = ($urandom_range(0, 3) == 0) ? 10'($urandom_range(1010, 1023))
                                       : 10'($urandom_range(0, 1023));
      fast_rsp = 1'($urandom_range(0, 1));
      run_cmd(d, $urandom() & 32'hFFFF_FFFC, u, l, $urandom_range(0, 3), 1'b0, "rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
